// File: rtl/seg7_capture_decoder.sv
// Samples a multiplexed active-low 7-segment bus and recovers the BCD digits shown.
// A sample must hold for STABLE_CYCLES synchronised cycles before it is decoded.
module seg7_capture_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel_n,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_out,
  output logic                  frame_valid,
  output logic                  err,
  output logic [2:0]            err_idx
);

  localparam int SW = DIGITS + 7;
  localparam logic [7:0] STABLE_C  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, HOLD = 2'd2} state_t;

  // Decoded pattern: {legal, blank, value}; pattern bit 6 is segment a.
  function automatic logic [5:0] seg_decode(input logic [6:0] p);
    logic [5:0] r;
    case (p)
      7'b0000001: r = {2'b10, 4'd0};
      7'b1001111: r = {2'b10, 4'd1};
      7'b0010010: r = {2'b10, 4'd2};
      7'b0000110: r = {2'b10, 4'd3};
      7'b1001100: r = {2'b10, 4'd4};
      7'b0100100: r = {2'b10, 4'd5};
      7'b0100000: r = {2'b10, 4'd6};
      7'b0001111: r = {2'b10, 4'd7};
      7'b0000000: r = {2'b10, 4'd8};
      7'b0000100: r = {2'b10, 4'd9};
      7'b1111111: r = {2'b01, 4'd0};
      default:    r = {2'b00, 4'd0};
    endcase
    return r;
  endfunction

  function automatic logic [2:0] sel_index(input logic [DIGITS-1:0] sel);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (!sel[k]) idx = 3'(k);
    end
    return idx;
  endfunction

  logic [SW-1:0]       sync1_q, sync2_q, prev_q;
  state_t              state_q;
  logic [7:0]          cnt_q;
  logic [DIGITS-1:0]   seen_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [DIGITS-1:0]   blank_q;
  logic                frame_q, err_q;
  logic [2:0]          err_idx_q;

  logic [DIGITS-1:0]   sel_s;
  logic [6:0]          seg_s, seg_abc_s;
  logic                valid_s, same_s, capture_s;
  logic [5:0]          dec_s;
  logic [2:0]          idx_s;
  logic [DIGITS-1:0]   seen_set_s;
  logic [4*DIGITS-1:0] bcd_cap_s;
  logic [DIGITS-1:0]   blank_cap_s;

  // Two-flop synchroniser for the asynchronous display lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {dig_sel_n, seg_in};
      sync2_q <= sync1_q;
    end
  end

  assign sel_s     = sync2_q[SW-1:7];
  assign seg_s     = sync2_q[6:0];
  assign seg_abc_s = {seg_s[0], seg_s[1], seg_s[2], seg_s[3], seg_s[4], seg_s[5], seg_s[6]};
  assign valid_s   = $onehot(~sel_s);
  assign same_s    = (sync2_q == prev_q);
  assign dec_s     = seg_decode(seg_abc_s);
  assign idx_s     = sel_index(sel_s);
  assign seen_set_s = seen_q | ~sel_s;

  // Next captured values if the current sample is committed.
  always_comb begin
    bcd_cap_s   = bcd_q;
    blank_cap_s = blank_q;
    capture_s   = 1'b0;
    if ((state_q == TRACK) && same_s && (cnt_q == STABLE_M1)) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (!sel_s[k] && dec_s[5]) begin
        bcd_cap_s[4*k +: 4] = dec_s[3:0];
        blank_cap_s[k]      = 1'b0;
      end else if (!sel_s[k] && dec_s[4]) begin
        blank_cap_s[k]      = 1'b1;
      end else begin
        blank_cap_s[k]      = blank_q[k];
      end
    end
  end

  // Stability FSM with capture, frame and error bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '1;
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      seen_q    <= '0;
      bcd_q     <= '0;
      blank_q   <= '1;
      frame_q   <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= 3'd0;
    end else begin
      prev_q  <= sync2_q;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
        cnt_q   <= 8'd0;
        seen_q  <= '0;
        bcd_q   <= '0;
        blank_q <= '1;
      end else begin
        case (state_q)
          IDLE: begin
            if (valid_s) begin
              state_q <= TRACK;
              cnt_q   <= 8'd1;
            end else begin
              cnt_q   <= 8'd0;
            end
          end
          TRACK: begin
            if (capture_s) begin
              state_q <= HOLD;
              cnt_q   <= STABLE_C;
            end else if (same_s) begin
              cnt_q   <= cnt_q + 8'd1;
            end else if (valid_s) begin
              cnt_q   <= 8'd1;
            end else begin
              state_q <= IDLE;
              cnt_q   <= 8'd0;
            end
          end
          HOLD: begin
            if (same_s) begin
              cnt_q   <= STABLE_C;
            end else if (valid_s) begin
              state_q <= TRACK;
              cnt_q   <= 8'd1;
            end else begin
              state_q <= IDLE;
              cnt_q   <= 8'd0;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
          end
        endcase
        if (capture_s) begin
          bcd_q   <= bcd_cap_s;
          blank_q <= blank_cap_s;
          if (seen_set_s == '1) begin
            frame_q <= 1'b1;
            seen_q  <= '0;
          end else begin
            seen_q  <= seen_set_s;
          end
          if (!dec_s[5] && !dec_s[4]) begin
            err_q     <= 1'b1;
            err_idx_q <= idx_s;
          end else begin
            err_q     <= 1'b0;
          end
        end else begin
          seen_q <= seen_q;
        end
      end
    end
  end

  assign bcd_out     = bcd_q;
  assign blank_out   = blank_q;
  assign frame_valid = frame_q;
  assign err         = err_q;
  assign err_idx     = err_idx_q;

endmodule
